systolic_pe_db: RTL and testbench

Next-generation weight-stationary systolic PE for the MAC array. It adds double-buffered weights, so the next tile's weight loads while the current tile computes, and a packed dual-lane low-precision mode computing a 2-element dot product per cycle. It also adds valid propagation alongside act/psum and a per-PE MAC activity counter. It sits in the array grid: activations flow west to east, partial sums flow north to south.

---
 rtl/systolic_pe_db_if.sv | 34 +++
 rtl/systolic_pe_db.sv | 105 ++++++++++
 tb/tb_systolic_pe_db.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/systolic_pe_db_if.sv
// Operand, control and result bundle for one weight-stationary systolic PE.
// The master modport drives the PE inputs; the slave modport is the PE's own view.
interface systolic_pe_db_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  enable;
  logic                  load_weight;
  logic                  swap_weight;
  logic                  quantize_mode;
  logic [DATA_WIDTH-1:0] act_in;
  logic                  act_valid_in;
  logic [ACC_WIDTH-1:0]  psum_in;
  logic [DATA_WIDTH-1:0] weight_load_in;
  logic                  clr_count;
  logic [DATA_WIDTH-1:0] act_out;
  logic                  act_valid_out;
  logic [ACC_WIDTH-1:0]  psum_out;
  logic [DATA_WIDTH-1:0] weight_active;
  logic [CNT_WIDTH-1:0]  mac_count;

  modport master (
    output enable, load_weight, swap_weight, quantize_mode, act_in, act_valid_in,
           psum_in, weight_load_in, clr_count,
    input  act_out, act_valid_out, psum_out, weight_active, mac_count
  );

  modport slave (
    input  enable, load_weight, swap_weight, quantize_mode, act_in, act_valid_in,
           psum_in, weight_load_in, clr_count,
    output act_out, act_valid_out, psum_out, weight_active, mac_count
  );
endinterface

// File: rtl/systolic_pe_db.sv
// Weight-stationary systolic PE with double-buffered weights, dual-lane packed MAC and
// a saturating MAC activity counter. Optional macro PE_SAT_EN: saturating accumulation.
module systolic_pe_db #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic            clk,
  input logic            rst,
  systolic_pe_db_if.slave pe
);
  localparam int HALF   = DATA_WIDTH / 2;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int LANE_W = DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] active_q, active_d;
  logic [DATA_WIDTH-1:0] act_q, act_d;
  logic                  valid_q, valid_d;
  logic [ACC_WIDTH-1:0]  psum_q, psum_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [PROD_W-1:0]     w_full, a_full, prod_full;
  logic [DATA_WIDTH-1:0] w_hi, w_lo, a_hi, a_lo, lane_hi, lane_lo;
  logic [LANE_W-1:0]     lane_sum;
  logic [ACC_WIDTH-1:0]  prod_ext, mac_sum;
`ifdef PE_SAT_EN
  logic [ACC_WIDTH:0]    sum_wide;
`endif

  // Operands are sign-extended to the product width up front, so plain multiplies give exact results.
  always_comb begin
    w_full    = {{DATA_WIDTH{active_q[DATA_WIDTH-1]}}, active_q};
    a_full    = {{DATA_WIDTH{pe.act_in[DATA_WIDTH-1]}}, pe.act_in};
    prod_full = w_full * a_full;
    w_hi      = {{HALF{active_q[DATA_WIDTH-1]}}, active_q[DATA_WIDTH-1:HALF]};
    w_lo      = {{HALF{active_q[HALF-1]}}, active_q[HALF-1:0]};
    a_hi      = {{HALF{pe.act_in[DATA_WIDTH-1]}}, pe.act_in[DATA_WIDTH-1:HALF]};
    a_lo      = {{HALF{pe.act_in[HALF-1]}}, pe.act_in[HALF-1:0]};
    lane_hi   = w_hi * a_hi;
    lane_lo   = w_lo * a_lo;
    lane_sum  = {lane_hi[DATA_WIDTH-1], lane_hi} + {lane_lo[DATA_WIDTH-1], lane_lo};
    if (pe.quantize_mode)
      prod_ext = {{(ACC_WIDTH-LANE_W){lane_sum[LANE_W-1]}}, lane_sum};
    else
      prod_ext = {{(ACC_WIDTH-PROD_W){prod_full[PROD_W-1]}}, prod_full};
  end

`ifdef PE_SAT_EN
  always_comb begin
    sum_wide = {pe.psum_in[ACC_WIDTH-1], pe.psum_in} + {prod_ext[ACC_WIDTH-1], prod_ext};
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
      mac_sum = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      mac_sum = sum_wide[ACC_WIDTH-1:0];
  end
`else
  always_comb begin
    mac_sum = pe.psum_in + prod_ext;
  end
`endif

  // Weight buffers ignore enable so the next tile can be staged while the array stalls.
  always_comb begin
    shadow_d = pe.load_weight ? pe.weight_load_in : shadow_q;
    active_d = pe.swap_weight ? shadow_q : active_q;
    act_d    = act_q;
    valid_d  = valid_q;
    psum_d   = psum_q;
    count_d  = count_q;
    if (pe.enable) begin
      act_d   = pe.act_in;
      valid_d = pe.act_valid_in;
      psum_d  = pe.act_valid_in ? mac_sum : pe.psum_in;
      if (pe.clr_count)
        count_d = '0;
      else if (pe.act_valid_in && (count_q != {CNT_WIDTH{1'b1}}))
        count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      act_q    <= '0;
      valid_q  <= 1'b0;
      psum_q   <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      act_q    <= act_d;
      valid_q  <= valid_d;
      psum_q   <= psum_d;
      count_q  <= count_d;
    end
  end

  assign pe.act_out       = act_q;
  assign pe.act_valid_out = valid_q;
  assign pe.psum_out      = psum_q;
  assign pe.weight_active = active_q;
  assign pe.mac_count     = count_q;
endmodule

// File: tb/tb_systolic_pe_db.sv
// Directed plus randomized bench for systolic_pe_db against an arithmetic reference model.
// A narrow counter keeps the saturation check short.
module tb_systolic_pe_db;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Reference state held as plain integers.
  longint m_shadow, m_active, m_act, m_valid, m_psum, m_cnt;

  systolic_pe_db_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  systolic_pe_db #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .pe  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic longint sx(input longint v, input int bits);
    longint m;
    m = v & ((64'sd1 <<< bits) - 1);
    if (m >= (64'sd1 <<< (bits - 1))) m = m - (64'sd1 <<< bits);
    return m;
  endfunction

  function automatic longint product(input longint w, input longint a, input bit q);
    if (!q) return sx(w, DW) * sx(a, DW);
    return sx(w >> (DW/2), DW/2) * sx(a >> (DW/2), DW/2)
         + sx(w, DW/2) * sx(a, DW/2);
  endfunction

  function automatic longint accumulate(input longint p, input longint prod);
    longint s;
    s = sx(p, AW) + prod;
`ifdef PE_SAT_EN
    if (s > (64'sd1 <<< (AW-1)) - 1) s = (64'sd1 <<< (AW-1)) - 1;
    if (s < -(64'sd1 <<< (AW-1)))    s = -(64'sd1 <<< (AW-1));
`endif
    return s & ((64'sd1 <<< AW) - 1);
  endfunction

  task automatic modelStep(input bit r, en, lw, sw, qm, clr,
                           input longint a, input bit v, input longint p, input longint wl);
    longint old_shadow, old_active;
    if (r) begin
      m_shadow = 0; m_active = 0; m_act = 0; m_valid = 0; m_psum = 0; m_cnt = 0;
      return;
    end
    old_shadow = m_shadow;
    old_active = m_active;
    if (lw) m_shadow = wl;
    if (sw) m_active = old_shadow;
    if (en) begin
      m_act   = a;
      m_valid = v;
      m_psum  = v ? accumulate(p, product(old_active, a, qm)) : p;
      if (clr) m_cnt = 0;
      else if (v && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (bus.act_out === DW'(m_act)) else begin
      bad++; $error("[TB] FAIL %s act_out got=%h exp=%h", tag, bus.act_out, DW'(m_act));
    end
    total++;
    assert (bus.act_valid_out === 1'(m_valid)) else begin
      bad++; $error("[TB] FAIL %s act_valid_out got=%b exp=%b", tag, bus.act_valid_out, 1'(m_valid));
    end
    total++;
    assert (bus.psum_out === AW'(m_psum)) else begin
      bad++; $error("[TB] FAIL %s psum_out got=%h exp=%h", tag, bus.psum_out, AW'(m_psum));
    end
    total++;
    assert (bus.weight_active === DW'(m_active)) else begin
      bad++; $error("[TB] FAIL %s weight_active got=%h exp=%h", tag, bus.weight_active, DW'(m_active));
    end
    total++;
    assert (bus.mac_count === CW'(m_cnt)) else begin
      bad++; $error("[TB] FAIL %s mac_count got=%0d exp=%0d", tag, bus.mac_count, CW'(m_cnt));
    end
  endtask

  task automatic checkPsum(input string tag, input logic [AW-1:0] want);
    total++;
    assert (bus.psum_out === want) else begin
      bad++; $error("[TB] FAIL %s psum_out got=%h exp=%h", tag, bus.psum_out, want);
    end
  endtask

  // Drives one cycle of inputs after the falling edge, advances the model on the rising edge, then checks.
  task automatic applyStimulus(input bit r, en, lw, sw, qm, clr,
                               input logic [DW-1:0] a, input bit v,
                               input logic [AW-1:0] p, input logic [DW-1:0] wl,
                               input string tag);
    rst                = r;
    bus.enable         = en;
    bus.load_weight    = lw;
    bus.swap_weight    = sw;
    bus.quantize_mode  = qm;
    bus.clr_count      = clr;
    bus.act_in         = a;
    bus.act_valid_in   = v;
    bus.psum_in        = p;
    bus.weight_load_in = wl;
    @(posedge clk);
    modelStep(r, en, lw, sw, qm, clr, longint'(a), v, longint'(p), longint'(wl));
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  initial begin
    m_shadow = 0; m_active = 0; m_act = 0; m_valid = 0; m_psum = 0; m_cnt = 0;
    @(negedge clk);

    //                 r  en lw sw qm clr act    v  psum           wl
    applyStimulus(1, 1, 1, 1, 0, 0, 8'h11, 1, 32'd55,        8'h22, "reset");
    applyStimulus(0, 1, 1, 0, 0, 0, 8'h00, 0, 32'd0,         8'hFD, "load_fd");
    applyStimulus(0, 1, 0, 1, 0, 0, 8'h00, 0, 32'd0,         8'h00, "swap_fd");
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h05, 1, 32'd100,       8'h00, "int8_mac");
    checkPsum("int8_literal", 32'd85);

    applyStimulus(0, 1, 1, 0, 0, 0, 8'h00, 0, 32'd0,         8'h3F, "load_3f");
    applyStimulus(0, 1, 0, 1, 0, 0, 8'h00, 0, 32'd0,         8'h00, "swap_3f");
    applyStimulus(0, 1, 0, 0, 1, 0, 8'h24, 1, 32'd10,        8'h00, "int4_dual");
    checkPsum("int4_literal", 32'd12);

    applyStimulus(0, 1, 1, 0, 0, 0, 8'h00, 0, 32'd0,         8'h02, "load_2");
    applyStimulus(0, 1, 0, 1, 0, 0, 8'h00, 0, 32'd0,         8'h00, "swap_2");
    applyStimulus(0, 1, 1, 0, 0, 0, 8'h03, 1, 32'd0,         8'h07, "stream_load7");
    checkPsum("db_before_swap", 32'd6);
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h03, 1, 32'd0,         8'h00, "stream_old_w");
    applyStimulus(0, 1, 1, 1, 0, 0, 8'h03, 1, 32'd0,         8'h09, "swap_and_load9");
    checkPsum("db_swap_edge", 32'd6);
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h03, 1, 32'd0,         8'h00, "mac_after_swap");
    checkPsum("db_new_w", 32'd21);
    applyStimulus(0, 1, 0, 1, 0, 0, 8'h03, 1, 32'd0,         8'h00, "swap_to_9");
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h03, 1, 32'd0,         8'h00, "mac_w9");
    checkPsum("db_shadow9", 32'd27);

    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 0, 1, 8'hA5, 1, 32'hDEAD, 8'h00, "stall");
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h44, 0, 32'h1234,     8'h00, "bubble");
    checkPsum("bubble_literal", 32'h1234);

    applyStimulus(0, 1, 1, 0, 0, 0, 8'h00, 0, 32'd0,         8'h7F, "load_7f");
    applyStimulus(0, 1, 0, 1, 0, 0, 8'h00, 0, 32'd0,         8'h00, "swap_7f");
    applyStimulus(0, 1, 0, 0, 0, 0, 8'h7F, 1, 32'h7FFFFFF0, 8'h00, "overflow");
`ifdef PE_SAT_EN
    checkPsum("overflow_literal", 32'h7FFFFFFF);
`else
    checkPsum("overflow_literal", 32'h80003EF1);
`endif

    applyStimulus(0, 1, 0, 0, 0, 1, 8'h01, 1, 32'd0,         8'h00, "clr_with_mac");
    for (int i = 0; i < (1 << CW) + 4; i++)
      applyStimulus(0, 1, 0, 0, 0, 0, DW'(i), 1, 32'd0,     8'h00, "count_sat");
    applyStimulus(0, 1, 1, 1, 1, 0, 8'h5A, 1, 32'h00FF00FF, 8'h6B, "pre_reset");
    applyStimulus(1, 1, 1, 1, 0, 0, 8'h33, 1, 32'h0000FFFF, 8'h44, "reset_mid");

    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
                    1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                    ($urandom_range(0, 19) == 0), DW'($urandom), ($urandom_range(0, 3) != 0),
                    AW'($urandom), DW'($urandom), "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
